// File: rtl/mult_seq_ctrl.sv
// Control FSM for a shift-add multiplier. It runs WIDTH evaluate/shift iterations per Run request.
// In signed mode the final iteration subtracts the multiplicand.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          ClearA_LoadB,
    input  logic          Signed_Mode,
    input  logic          B_lsb,
    output logic          Clr_Ld,
    output logic          Shift,
    output logic          Add,
    output logic          Sub,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Step
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EVAL  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [CW-1:0] STEP_LAST = CW'(WIDTH - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    logic          mode_q, mode_d;
    logic          last;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
        end
    end

    assign last = (step_q == STEP_LAST);

    // Next state and datapath strobes; Add/Sub are Mealy on the multiplier LSB.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        mode_d  = mode_q;
        Clr_Ld  = 1'b0;
        Shift   = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        case (state_q)
            S_IDLE: begin
                step_d = '0;
                if (Run) begin
                    state_d = S_EVAL;
                    mode_d  = Signed_Mode;
                end else begin
                    Clr_Ld = ClearA_LoadB;
                end
            end
            S_EVAL: begin
                Add     = B_lsb & ~(last & mode_q);
                Sub     = B_lsb & last & mode_q;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                Shift = 1'b1;
                if (last) begin
                    state_d = S_HOLD;
                    step_d  = '0;
                end else begin
                    state_d = S_EVAL;
                    step_d  = step_q + CW'(1);
                end
            end
            S_HOLD: begin
                // Holding until Run drops gives exactly one multiply per Run assertion.
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    assign Busy = (state_q == S_EVAL) || (state_q == S_SHIFT);
    assign Done = (state_q == S_HOLD);
    assign Step = step_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: a WIDTH=8 controller drives a reference shift-add datapath.
// WIDTH=4 and WIDTH=16 controllers run alongside with B_lsb tied high.
module tb_mult_seq_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset, Run, clr_in, sig_mode, b8, bx;
    logic clr8, sh8, add8, sub8, busy8, done8;
    logic clr4, sh4, add4, sub4, busy4, done4;
    logic clr16, sh16, add16, sub16, busy16, done16;
    logic [2:0] step8;
    logic [1:0] step4;
    logic [3:0] step16;

    mult_seq_ctrl u8 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(clr_in), .Signed_Mode(sig_mode),
        .B_lsb(b8), .Clr_Ld(clr8), .Shift(sh8), .Add(add8), .Sub(sub8),
        .Busy(busy8), .Done(done8), .Step(step8)
    );
    mult_seq_ctrl #(.WIDTH(4)) u4 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(clr_in), .Signed_Mode(sig_mode),
        .B_lsb(bx), .Clr_Ld(clr4), .Shift(sh4), .Add(add4), .Sub(sub4),
        .Busy(busy4), .Done(done4), .Step(step4)
    );
    mult_seq_ctrl #(.WIDTH(16)) u16 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(clr_in), .Signed_Mode(sig_mode),
        .B_lsb(bx), .Clr_Ld(clr16), .Shift(sh16), .Add(add16), .Sub(sub16),
        .Busy(busy16), .Done(done16), .Step(step16)
    );

    // Reference datapath: 9-bit accumulator A, multiplier B, multiplicand S.
    logic [8:0] acc;
    logic [7:0] mb, mc, ld_b;
    logic       dp_mode;

    always @(posedge Clk) begin
        if (Reset) begin
            acc <= '0;
            mb  <= '0;
        end else if (clr8) begin
            acc <= '0;
            mb  <= ld_b;
        end else if (add8) begin
            acc <= acc + {dp_mode & mc[7], mc};
        end else if (sub8) begin
            acc <= acc - {dp_mode & mc[7], mc};
        end else if (sh8) begin
            {acc, mb} <= {dp_mode & acc[8], acc, mb[7:1]};
        end
    end
    assign b8 = mb[0];

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Per-cycle invariants on strobe exclusivity and state decodes.
    always @(negedge Clk) begin
        if (mon_en) begin
            chk("add_sub_excl8", 32'(add8 & sub8), 32'd0);
            chk("onehot8", 32'($onehot0({clr8, sh8, add8 | sub8})), 32'd1);
            chk("sub_last8", 32'(!sub8 || step8 == 3'd7), 32'd1);
            chk("step_hold8", 32'(!done8 || step8 == 3'd0), 32'd1);
            chk("busy_done8", 32'(busy8 & done8), 32'd0);
            chk("add_sub_excl4", 32'(add4 & sub4), 32'd0);
            chk("add_sub_excl16", 32'(add16 & sub16), 32'd0);
            chk("sub_last4", 32'(!sub4 || step4 == 2'd3), 32'd1);
            chk("sub_last16", 32'(!sub16 || step16 == 4'd15), 32'd1);
        end
    end

    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic md,
                          input logic flip, input logic [15:0] expp);
        int na8, ns8, nsh8, na4, ns4, na16, ns16, d8, d4, d16, bits;
        logic [15:0] want;
        na8 = 0; ns8 = 0; nsh8 = 0; na4 = 0; ns4 = 0; na16 = 0; ns16 = 0;
        d8 = 0; d4 = 0; d16 = 0;
        ld_b = b; mc = a; dp_mode = md; sig_mode = md; clr_in = 1'b1; Run = 1'b0;
        #1;
        chk("clr_ld_idle", 32'(clr8), 32'd1);
        tick;
        clr_in = 1'b0;
        exp_q.push_back(expp);
        Run = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (flip && n == 2) begin
                sig_mode = ~md;
                clr_in   = 1'b1;
            end
            if (busy8) chk("step_idx", 32'(step8), 32'((n - 1) / 2));
            na8 += int'(add8);   ns8 += int'(sub8);   nsh8 += int'(sh8);
            na4 += int'(add4);   ns4 += int'(sub4);
            na16 += int'(add16); ns16 += int'(sub16);
            if (done4 && d4 == 0) d4 = n;
            if (done16 && d16 == 0) d16 = n;
            if (done8 && d8 == 0) begin
                d8 = n;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    chk("product", 32'({acc[7:0], mb}), 32'(want));
                end
            end
        end
        bits = $countones(b);
        chk("done_lat8", 32'(d8 - 1), 32'd16);
        chk("done_lat4", 32'(d4 - 1), 32'd8);
        chk("done_lat16", 32'(d16 - 1), 32'd32);
        chk("add_cnt8", 32'(na8), 32'(bits - int'(md & b[7])));
        chk("sub_cnt8", 32'(ns8), 32'(md & b[7]));
        chk("shift_cnt8", 32'(nsh8), 32'd8);
        chk("add_cnt4", 32'(na4), 32'(4 - int'(md)));
        chk("sub_cnt4", 32'(ns4), 32'(md));
        chk("add_cnt16", 32'(na16), 32'(16 - int'(md)));
        chk("sub_cnt16", 32'(ns16), 32'(md));
        chk("hold_done", 32'({done8, done4, done16, busy8}), 32'b1110);
        Run = 1'b0; sig_mode = md; clr_in = 1'b0;
        tick;
        chk("idle_after_hold", 32'({busy8, done8, step8}), 32'd0);
    endtask

    typedef struct {
        logic run;
        logic clr;
        logic exp_clr_ld;
    } idle_vec_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        md;
        logic        flip;
        logic [15:0] p;
    } mul_vec_t;

    idle_vec_t iv[4];
    mul_vec_t  mv[9];

    initial begin
        bit found;
        iv[0] = '{1'b0, 1'b0, 1'b0};
        iv[1] = '{1'b0, 1'b1, 1'b1};
        iv[2] = '{1'b1, 1'b0, 1'b0};
        iv[3] = '{1'b1, 1'b1, 1'b0};
        mv[0] = '{8'd3,   8'd5,   1'b0, 1'b0, 16'h000F};
        mv[1] = '{8'd255, 8'd255, 1'b0, 1'b0, 16'hFE01};
        mv[2] = '{8'd0,   8'd200, 1'b0, 1'b0, 16'h0000};
        mv[3] = '{8'hFD,  8'd5,   1'b1, 1'b0, 16'hFFF1};
        mv[4] = '{8'd7,   8'hFE,  1'b1, 1'b0, 16'hFFF2};
        mv[5] = '{8'h80,  8'h80,  1'b1, 1'b0, 16'h4000};
        mv[6] = '{8'hFF,  8'hFF,  1'b1, 1'b0, 16'h0001};
        mv[7] = '{8'd100, 8'hFF,  1'b1, 1'b0, 16'hFF9C};
        mv[8] = '{8'd3,   8'h80,  1'b0, 1'b1, 16'h0180};

        Reset = 1'b1; Run = 1'b0; clr_in = 1'b0; sig_mode = 1'b0;
        dp_mode = 1'b0; ld_b = '0; mc = '0; bx = 1'b1;
        tick; tick;
        Reset = 1'b0;
        tick;
        chk("reset_outs", 32'({busy8, done8, sh8, add8, sub8, clr8, step8}), 32'd0);
        mon_en = 1'b1;

        // Clr_Ld decode in IDLE; each row is withdrawn before the clock edge.
        foreach (iv[i]) begin
            Run = iv[i].run; clr_in = iv[i].clr;
            #1;
            chk("idle_clr_ld8", 32'(clr8), 32'(iv[i].exp_clr_ld));
            chk("idle_clr_ld4", 32'(clr4), 32'(iv[i].exp_clr_ld));
            Run = 1'b0; clr_in = 1'b0;
            tick;
            chk("idle_stays", 32'(busy8), 32'd0);
        end

        // Start wins over ClearA_LoadB, then reset mid-operation at step 3.
        Run = 1'b1; clr_in = 1'b1;
        #1;
        chk("start_wins_clr", 32'(clr8), 32'd0);
        tick;
        chk("eval_after_start", 32'({busy8, done8, step8}), 32'b1_0_000);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (busy8 && !sh8 && step8 == 3'd3) found = 1'b1;
            else tick;
        end
        chk("reach_step3", 32'(found), 32'd1);
        clr_in = 1'b0;
        Reset = 1'b1;
        tick;
        Reset = 1'b0; Run = 1'b0;
        chk("reset_midop", 32'({busy8, done8, sh8, add8, sub8, clr8, step8}), 32'd0);
        chk("reset_midop16", 32'({busy16, done16, step16}), 32'd0);
        tick;

        foreach (mv[i]) do_mul(mv[i].a, mv[i].b, mv[i].md, mv[i].flip, mv[i].p);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, which is also the number of add/shift iterations; legal range 2..32.
REQ-002 Parameter CW, default $clog2(WIDTH): width of the step counter, with a minimum of 1.
REQ-003 Port Clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port Run, input, 1 bit: level start request.
REQ-006 Port ClearA_LoadB, input, 1 bit: clear accumulator and load multiplier request, honoured only when idle.
REQ-007 Port Signed_Mode, input, 1 bit: 1 selects two's-complement multiplier (last step subtracts); 0 selects unsigned (last step adds).
REQ-008 Port B_lsb, input, 1 bit: current multiplier LSB from the datapath shift register.
REQ-009 Port Clr_Ld, output, 1 bit: clear A and load B strobe.
REQ-010 Port Shift, output, 1 bit: arithmetic right shift of the A:B register pair.
REQ-011 Port Add, output, 1 bit: A <= A + S.
REQ-012 Port Sub, output, 1 bit: A <= A - S.
REQ-013 Port Busy, output, 1 bit: high while an operation is in progress.
REQ-014 Port Done, output, 1 bit: high while the result is held.
REQ-015 Port Step, output, CW bits: current iteration index, 0..WIDTH-1.

Function
REQ-016 The FSM SHALL have four states: IDLE, EVAL, SHIFT and HOLD, with an explicit default arm returning to IDLE.
REQ-017 IDLE: Run=1 -> EVAL; the counter is loaded with 0 and Signed_Mode is latched into mode_q. Otherwise the FSM stays in IDLE.
REQ-018 EVAL -> SHIFT unconditionally.
REQ-019 SHIFT: if Step==WIDTH-1 -> HOLD; otherwise Step increments and the FSM goes to EVAL.
REQ-020 HOLD: Run=0 -> IDLE; Run=1 -> stay in HOLD, so one Run assertion yields exactly one multiply.
REQ-021 IDLE outputs: Clr_Ld=ClearA_LoadB when Run=0, else 0. Shift=Add=Sub=0.
REQ-022 EVAL outputs (Mealy on B_lsb): Add=B_lsb & ~(last & mode_q), Sub=B_lsb & last & mode_q, where last = (Step==WIDTH-1). Shift=0, Clr_Ld=0.
REQ-023 SHIFT outputs: Shift=1; all other strobes 0.
REQ-024 HOLD outputs: all strobes 0.
REQ-025 Add and Sub SHALL never both be 1; at most one of Clr_Ld, Shift, and Add|Sub is 1 in any cycle.
REQ-026 Busy=1 in EVAL and SHIFT; Done=1 in HOLD only; both are registered state decodes, not input-dependent.
REQ-027 Latency: the first EVAL is 1 cycle after Run is sampled high in IDLE; HOLD is entered exactly 2*WIDTH cycles after leaving IDLE.
REQ-028 Signed_Mode and ClearA_LoadB changes while Busy SHALL have no effect; mode_q holds its value until the next start.
REQ-029 Step SHALL be 0 in IDLE and HOLD, and never exceed WIDTH-1 (no wrap).
REQ-030 If Run and ClearA_LoadB are both 1 in IDLE, the start SHALL win and Clr_Ld=0.
REQ-031 All outputs SHALL be defined (no X) for every state and input combination; there are no latches.

Reset
REQ-032 Reset=1 at a rising edge SHALL force the FSM to IDLE, Step=0 and mode_q=0, from any state including mid-operation.
REQ-033 Reset SHALL take priority over Run.
REQ-034 Outputs after reset: Busy=0, Done=0, Shift=Add=Sub=0; Clr_Ld follows REQ-021.

Verification
REQ-035 WIDTH=8, Signed_Mode=0, Run high with B_lsb=1 in every EVAL -> 8 Add pulses, 8 Shift pulses, Sub never asserted, Done after 16 cycles.
REQ-036 WIDTH=8, Signed_Mode=1, B_lsb=1 in every EVAL -> Add in steps 0..6, Sub in step 7, Done=1 at cycle 16.
REQ-037 Run held high for 40 cycles -> exactly one 16-cycle sequence, then Done=1 until Run falls, then IDLE next cycle.
REQ-038 Reset pulsed during step 3 SHALL return the FSM to IDLE with Step=0 and all strobes 0; a later Run -> full 16-cycle sequence.
REQ-039 In IDLE, ClearA_LoadB=1 with Run=0 -> Clr_Ld=1; with Run=1 -> Clr_Ld=0 and EVAL next cycle.
REQ-040 WIDTH=4 and WIDTH=16 builds -> HOLD at cycle 8 and cycle 32 respectively, with Sub only in the final EVAL when Signed_Mode=1.
